tap_pwm_gen: RTL

//  Downstream consumer of the clock_divider taps (div_by_2/4/8/16), all in the clk domain.
//  - Selects one tap, converts its rising edge into a single-cycle tick enable.
//  - Drives a CNT_W-bit PWM counter from that tick.
//  - Duty cycle is updated by a load/ack handshake and applied glitch-free at the period boundary.
//  - Taps are never used as clocks; all logic runs on clk.

---
 rtl/tap_pwm_gen_if.sv | 11 +
 rtl/tap_pwm_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tap_pwm_gen_if.sv
// Duty-cycle load/ack handshake between a controller (master) and tap_pwm_gen (slave).
interface tap_pwm_gen_if #(
   parameter int CNT_W = 8
);
   logic [CNT_W-1:0] duty_in;
   logic             duty_load;
   logic             duty_ack;

   modport master (output duty_in, output duty_load, input duty_ack);
   modport slave  (input duty_in, input duty_load, output duty_ack);
endinterface

// File: rtl/tap_pwm_gen.sv
// tap_pwm_gen: turns a selected clock_divider tap into a tick enable and drives a PWM from it.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter instead of a sawtooth.
module tap_pwm_gen #(
   parameter int CNT_W        = 8,
   parameter int DEFAULT_DUTY = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         div_by_2,
   input  logic         div_by_4,
   input  logic         div_by_8,
   input  logic         div_by_16,
   input  logic [1:0]   tap_sel,
   input  logic         en,
   tap_pwm_gen_if.slave duty_if,
   output logic         tick,
   output logic         pwm_out,
   output logic         period_done
);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] DUTY_RST = DEFAULT_DUTY[CNT_W-1:0];

   logic             tap_mux_s, wrap_s, xfer_s;
   logic             tap_q, tap_d;
   logic [1:0]       sel_q, sel_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pwm_q, pwm_d;
   logic             pd_q, pd_d;
   logic             xfer_q, xfer_d;
   logic             ack_q, ack_d;
   logic [CNT_W-1:0] duty_act_q, duty_act_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             pend_q, pend_d;
`ifdef PWM_CENTER_ALIGN_EN
   logic             dir_up_q, dir_up_d;
`endif

   // Next-state logic: tap edge detection, PWM counter and duty handshake.
   always_comb begin
      case (tap_sel)
         2'd0:    tap_mux_s = div_by_2;
         2'd1:    tap_mux_s = div_by_4;
         2'd2:    tap_mux_s = div_by_8;
         2'd3:    tap_mux_s = div_by_16;
         default: tap_mux_s = 1'b0;
      endcase
      tap_d  = tap_mux_s;
      sel_d  = tap_sel;
      // A select change compares against a different tap's history, so drop that edge.
      tick_d = tap_mux_s & ~tap_q & (tap_sel == sel_q);

      cnt_d  = cnt_q;
      wrap_s = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_up_d = dir_up_q;
      if (!en) begin
         cnt_d    = CNT_ZERO;
         dir_up_d = 1'b1;
      end else if (tick_q) begin
         if (dir_up_q) begin
            if (cnt_q == CNT_MAX) begin
               cnt_d    = cnt_q - CNT_ONE;
               dir_up_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               dir_up_d = 1'b1;
               wrap_s   = 1'b1;
            end else begin
               wrap_s = 1'b0;
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
`else
      if (!en) begin
         cnt_d = CNT_ZERO;
      end else if (tick_q) begin
         cnt_d  = cnt_q + CNT_ONE;
         wrap_s = (cnt_q == CNT_MAX);
      end else begin
         cnt_d = cnt_q;
      end
`endif
      pd_d  = wrap_s;
      pwm_d = en & (cnt_q < duty_act_q);

      // Duty is swapped at the period boundary, or at once while the PWM is stopped.
      xfer_s     = pend_q & (wrap_s | ~en);
      xfer_d     = xfer_s;
      ack_d      = xfer_q;
      duty_act_d = xfer_s ? pending_q : duty_act_q;
      if (duty_if.duty_load) begin
         pending_d = duty_if.duty_in;
         pend_d    = 1'b1;
      end else if (xfer_s) begin
         pending_d = pending_q;
         pend_d    = 1'b0;
      end else begin
         pending_d = pending_q;
         pend_d    = pend_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap_q      <= 1'b0;
         sel_q      <= 2'd0;
         tick_q     <= 1'b0;
         cnt_q      <= CNT_ZERO;
         pwm_q      <= 1'b0;
         pd_q       <= 1'b0;
         xfer_q     <= 1'b0;
         ack_q      <= 1'b0;
         duty_act_q <= DUTY_RST;
         pending_q  <= CNT_ZERO;
         pend_q     <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_up_q   <= 1'b1;
`endif
      end else begin
         tap_q      <= tap_d;
         sel_q      <= sel_d;
         tick_q     <= tick_d;
         cnt_q      <= cnt_d;
         pwm_q      <= pwm_d;
         pd_q       <= pd_d;
         xfer_q     <= xfer_d;
         ack_q      <= ack_d;
         duty_act_q <= duty_act_d;
         pending_q  <= pending_d;
         pend_q     <= pend_d;
`ifdef PWM_CENTER_ALIGN_EN
         dir_up_q   <= dir_up_d;
`endif
      end
   end

   assign tick             = tick_q;
   assign pwm_out          = pwm_q;
   assign period_done      = pd_q;
   assign duty_if.duty_ack = ack_q;
endmodule
